// File: rtl/cur_mb_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : cur_mb_fetch
//  Purpose  : Fetches one 4:2:0 planar macroblock (16 luma, 8 Cb, 8 Cr rows)
//             from external memory into the current-MB buffer on each start
//             pulse, then raises done for the top controller.
//  Revision : 1.0  initial release
// ============================================================================
module cur_mb_fetch #(
    parameter int PIC_W_MB_LEN = 8,
    parameter int PIC_H_MB_LEN = 8,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 128,
    parameter int MAX_OUTST    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [PIC_W_MB_LEN-1:0] mb_x_i,
    input  logic [PIC_H_MB_LEN-1:0] mb_y_i,
    input  logic [PIC_W_MB_LEN-1:0] x_total_i,
    input  logic [ADDR_W-1:0]       y_base_i,
    input  logic [ADDR_W-1:0]       cb_base_i,
    input  logic [ADDR_W-1:0]       cr_base_i,
    output logic                    rd_req_o,
    output logic [ADDR_W-1:0]       rd_addr_o,
    input  logic                    rd_ack_i,
    input  logic                    rd_valid_i,
    input  logic [DATA_W-1:0]       rd_data_i,
    output logic                    buf_wr_en_o,
    output logic [4:0]              buf_wr_addr_o,
    output logic [DATA_W-1:0]       buf_wr_data_o,
    output logic                    done_o,
    output logic                    busy_o,
    output logic                    start_err_o
);

    // Outstanding counter must hold 0..MAX_OUTST (MAX_OUTST <= 8).
    localparam int             OUT_W = 4;
    localparam logic [OUT_W-1:0] MAX_O = OUT_W'(MAX_OUTST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_REQ   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                  state;
    logic [PIC_W_MB_LEN-1:0] mb_x;
    logic [PIC_H_MB_LEN-1:0] mb_y;
    logic [PIC_W_MB_LEN-1:0] x_total;
    logic [ADDR_W-1:0]       y_base;
    logic [ADDR_W-1:0]       cb_base;
    logic [ADDR_W-1:0]       cr_base;
    logic [ADDR_W-1:0]       stride_y;
    logic [ADDR_W-1:0]       stride_c;
    logic [ADDR_W-1:0]       cb_row0;
    logic [ADDR_W-1:0]       cr_row0;
    logic [5:0]              req_cnt;
    logic [5:0]              rsp_cnt;
    logic [OUT_W-1:0]        outst;

    logic                    accept;
    logic                    beat;
    logic [OUT_W-1:0]        outst_nx;
    logic [ADDR_W-1:0]       mbs_per_row;
    logic [ADDR_W-1:0]       stride_y_calc;
    logic [ADDR_W-1:0]       stride_c_calc;
    logic [ADDR_W-1:0]       y_row0_calc;
    logic [ADDR_W-1:0]       cb_row0_calc;
    logic [ADDR_W-1:0]       cr_row0_calc;

    // Handshake qualification and the one-off row-0 address arithmetic used in CALC.
    always_comb begin
        accept        = rd_req_o & rd_ack_i;
        // Beats with nothing outstanding (or while idle) are strays, e.g. after a reset.
        beat          = rd_valid_i & (state != S_IDLE) & (outst != '0);
        outst_nx      = outst + OUT_W'(accept) - OUT_W'(beat);
        mbs_per_row   = ADDR_W'(x_total) + ADDR_W'(1);
        stride_y_calc = mbs_per_row << 4;
        stride_c_calc = mbs_per_row << 3;
        y_row0_calc   = y_base  + ((ADDR_W'(mb_y) * stride_y_calc) << 4) + (ADDR_W'(mb_x) << 4);
        cb_row0_calc  = cb_base + ((ADDR_W'(mb_y) * stride_c_calc) << 3) + (ADDR_W'(mb_x) << 3);
        cr_row0_calc  = cr_base + ((ADDR_W'(mb_y) * stride_c_calc) << 3) + (ADDR_W'(mb_x) << 3);
    end

    // Control FSM, request address walk, response counting and buffer write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            mb_x          <= '0;
            mb_y          <= '0;
            x_total       <= '0;
            y_base        <= '0;
            cb_base       <= '0;
            cr_base       <= '0;
            stride_y      <= '0;
            stride_c      <= '0;
            cb_row0       <= '0;
            cr_row0       <= '0;
            req_cnt       <= '0;
            rsp_cnt       <= '0;
            outst         <= '0;
            rd_req_o      <= 1'b0;
            rd_addr_o     <= '0;
            buf_wr_en_o   <= 1'b0;
            buf_wr_addr_o <= '0;
            buf_wr_data_o <= '0;
            done_o        <= 1'b0;
            busy_o        <= 1'b0;
            start_err_o   <= 1'b0;
        end else begin
            outst       <= outst_nx;
            buf_wr_en_o <= beat;
            if (beat) begin
                buf_wr_addr_o <= rsp_cnt[4:0];
                buf_wr_data_o <= rd_data_i;
                rsp_cnt       <= rsp_cnt + 6'd1;
            end

            if (start_i && (state != S_IDLE)) begin
                start_err_o <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        mb_x    <= mb_x_i;
                        mb_y    <= mb_y_i;
                        x_total <= x_total_i;
                        y_base  <= y_base_i;
                        cb_base <= cb_base_i;
                        cr_base <= cr_base_i;
                        req_cnt <= '0;
                        rsp_cnt <= '0;
                        done_o  <= 1'b0;
                        busy_o  <= 1'b1;
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    stride_y  <= stride_y_calc;
                    stride_c  <= stride_c_calc;
                    cb_row0   <= cb_row0_calc;
                    cr_row0   <= cr_row0_calc;
                    rd_addr_o <= y_row0_calc;
                    rd_req_o  <= 1'b1;
                    state     <= S_REQ;
                end
                S_REQ: begin
                    if (accept) begin
                        req_cnt <= req_cnt + 6'd1;
                        // Plane switches jump to the stored row-0 address; otherwise step by stride.
                        case (req_cnt)
                            6'd15:   rd_addr_o <= cb_row0;
                            6'd23:   rd_addr_o <= cr_row0;
                            default: rd_addr_o <= rd_addr_o + ((req_cnt < 6'd16) ? stride_y : stride_c);
                        endcase
                    end
                    if (accept && (req_cnt == 6'd31)) begin
                        rd_req_o <= 1'b0;
                        state    <= S_DRAIN;
                    end else begin
                        rd_req_o <= (outst_nx < MAX_O);
                    end
                end
                S_DRAIN: begin
                    if (rsp_cnt == 6'd32) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cur_mb_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cur_mb_fetch
//  Purpose  : Self-checking bench for cur_mb_fetch with a memory responder
//             and an address/data reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cur_mb_fetch;

    localparam int MAXO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [7:0]   mb_x_i = '0, mb_y_i = '0, x_total_i = '0;
    logic [31:0]  y_base_i = '0, cb_base_i = '0, cr_base_i = '0;
    logic         rd_req_o;
    logic [31:0]  rd_addr_o;
    logic         rd_ack_i = 1'b0;
    logic         rd_valid_i = 1'b0;
    logic [127:0] rd_data_i = '0;
    logic         buf_wr_en_o;
    logic [4:0]   buf_wr_addr_o;
    logic [127:0] buf_wr_data_o;
    logic         done_o, busy_o, start_err_o;

    always #5 clk = ~clk;

    cur_mb_fetch #(
        .PIC_W_MB_LEN (8),
        .PIC_H_MB_LEN (8),
        .ADDR_W       (32),
        .DATA_W       (128),
        .MAX_OUTST    (MAXO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .mb_x_i        (mb_x_i),
        .mb_y_i        (mb_y_i),
        .x_total_i     (x_total_i),
        .y_base_i      (y_base_i),
        .cb_base_i     (cb_base_i),
        .cr_base_i     (cr_base_i),
        .rd_req_o      (rd_req_o),
        .rd_addr_o     (rd_addr_o),
        .rd_ack_i      (rd_ack_i),
        .rd_valid_i    (rd_valid_i),
        .rd_data_i     (rd_data_i),
        .buf_wr_en_o   (buf_wr_en_o),
        .buf_wr_addr_o (buf_wr_addr_o),
        .buf_wr_data_o (buf_wr_data_o),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .start_err_o   (start_err_o)
    );

    // Reference configuration of the macroblock being fetched
    logic [7:0]   m_x, m_y, m_xt;
    logic [31:0]  m_yb, m_cb, m_cr;
    int           lat = 2;
    int           ack_pct = 100;
    bit           mem_on = 0, start_pend = 0, force_valid = 0, exp_wr = 0;
    bit           prev_req = 0, prev_ack = 0;
    logic [31:0]  prev_addr = '0;
    int           cyc = 0, req_idx = 0, rsp_idx = 0, wr_idx = 0;
    int           due_q[$];
    logic [127:0] dat[32];
    logic [31:0]  seen_addr[32];
    int           total = 0, bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Row address straight from the plane geometry: base + row offset + column offset + row*stride.
    function automatic logic [31:0] model_addr(input int r);
        logic [31:0] sy, sc, base;
        sy = (32'(m_xt) + 32'd1) * 32'd16;
        sc = (32'(m_xt) + 32'd1) * 32'd8;
        if (r < 16)
            return m_yb + 32'(m_y) * 32'd16 * sy + 32'(m_x) * 32'd16 + 32'(r) * sy;
        base = (r < 24) ? m_cb : m_cr;
        return base + 32'(m_y) * 32'd8 * sc + 32'(m_x) * 32'd8 + 32'((r < 24) ? r - 16 : r - 24) * sc;
    endfunction

    // One clock of the memory responder plus per-cycle protocol checks, all at the falling edge.
    task automatic step();
        logic ack;
        int   outst;
        @(negedge clk);
        cyc++;
        chk("wr_en", buf_wr_en_o, exp_wr);
        if (buf_wr_en_o && exp_wr) begin
            if (wr_idx < 32) begin
                chk("wr_addr", buf_wr_addr_o, wr_idx[4:0]);
                chk("wr_data", buf_wr_data_o, dat[wr_idx]);
            end
            wr_idx++;
        end
        if (mem_on) begin
            outst = req_idx - rsp_idx;
            if (rd_req_o) chk("req_while_full", outst < MAXO, 1'b1);
            if (prev_req && !prev_ack) begin
                chk("req_held", rd_req_o, 1'b1);
                chk("addr_held", rd_addr_o, prev_addr);
            end
        end
        ack = mem_on && ($urandom_range(99) < ack_pct);
        rd_ack_i = ack;
        if (rd_req_o && ack) begin
            if (req_idx < 32) begin
                chk("req_addr", rd_addr_o, model_addr(req_idx));
                seen_addr[req_idx] = rd_addr_o;
                dat[req_idx] = {$urandom, $urandom, $urandom, $urandom};
                due_q.push_back(cyc + 1 + lat);
            end else begin
                chk("extra_req", req_idx, 31);
            end
            req_idx++;
        end
        exp_wr = 0;
        if (force_valid) begin
            rd_valid_i  = 1'b1;
            rd_data_i   = {$urandom, $urandom, $urandom, $urandom};
            force_valid = 0;
        end else if (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
            void'(due_q.pop_front());
            rd_valid_i = 1'b1;
            rd_data_i  = dat[rsp_idx];
            rsp_idx++;
            exp_wr = 1;
        end else begin
            rd_valid_i = 1'b0;
            rd_data_i  = {$urandom, $urandom, $urandom, $urandom};
        end
        start_i    = start_pend;
        start_pend = 0;
        prev_req   = rd_req_o;
        prev_addr  = rd_addr_o;
        prev_ack   = ack;
    endtask

    task automatic drive_cfg();
        mb_x_i = m_x; mb_y_i = m_y; x_total_i = m_xt;
        y_base_i = m_yb; cb_base_i = m_cb; cr_base_i = m_cr;
    endtask

    // Whole macroblock fetch; optional latency bound and optional mid-fetch start pulse.
    task automatic run_fetch(input int bound, input int err_at);
        int s;
        req_idx = 0; rsp_idx = 0; wr_idx = 0; due_q.delete(); mem_on = 1;
        drive_cfg();
        start_pend = 1;
        step();
        s = cyc + 1;
        step();
        chk("busy_after_start", busy_o, 1'b1);
        chk("done_cleared", done_o, 1'b0);
        for (int i = 0; i < 4000 && !done_o; i++) begin
            if (i == err_at) begin
                mb_x_i = ~m_x; mb_y_i = ~m_y; x_total_i = ~m_xt;
                y_base_i = ~m_yb; cb_base_i = ~m_cb; cr_base_i = ~m_cr;
                start_pend = 1;
            end
            if (i == err_at + 1) drive_cfg();
            step();
        end
        chk("done_reached", done_o, 1'b1);
        chk("busy_low_at_done", busy_o, 1'b0);
        chk("rows_written", wr_idx, 32);
        chk("reqs_issued", req_idx, 32);
        if (bound > 0) chk("latency_bound", (cyc - s) <= bound, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_req"}, rd_req_o, 1'b0);
        chk({tag, "_rd_addr"}, rd_addr_o, 32'h0);
        chk({tag, "_wr_en"}, buf_wr_en_o, 1'b0);
        chk({tag, "_wr_addr"}, buf_wr_addr_o, 5'h0);
        chk({tag, "_wr_data"}, buf_wr_data_o, 128'h0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_start_err"}, start_err_o, 1'b0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // 1: directed geometry, full-rate ack, latency 2
        m_x = 8'd1; m_y = 8'd2; m_xt = 8'd3;
        m_yb = 32'h0000_1000; m_cb = 32'h2000_0000; m_cr = 32'h3000_0000;
        lat = 2; ack_pct = 100;
        run_fetch(2 + 32 * 1 + 2 + 1, -1);
        chk("t1_req0", seen_addr[0], 32'h0000_1810);
        chk("t1_req1", seen_addr[1], 32'h0000_1850);
        chk("t1_req16", seen_addr[16], 32'h2000_0208);

        // 2: long latency saturates the outstanding window
        m_xt = 8'($urandom_range(255)); m_x = 8'($urandom_range(m_xt));
        m_y = 8'($urandom); m_yb = $urandom; m_cb = $urandom; m_cr = $urandom;
        lat = 10; ack_pct = 100;
        run_fetch(2 + 32 * 3 + 10 + 1, -1);

        // 3: sparse random acceptance
        m_xt = 8'($urandom_range(255)); m_x = 8'($urandom_range(m_xt));
        m_y = 8'($urandom); m_yb = $urandom; m_cb = $urandom; m_cr = $urandom;
        lat = 3; ack_pct = 30;
        run_fetch(0, -1);

        // 4: start while busy is flagged and ignored; a second start re-arms done
        chk("t4_err_before", start_err_o, 1'b0);
        m_xt = 8'($urandom_range(255)); m_x = 8'($urandom_range(m_xt));
        m_y = 8'($urandom); m_yb = $urandom; m_cb = $urandom; m_cr = $urandom;
        lat = 4; ack_pct = 100;
        run_fetch(0, 8);
        chk("t4_err_set", start_err_o, 1'b1);
        m_x = 8'($urandom_range(m_xt)); m_y = 8'($urandom);
        run_fetch(0, -1);
        chk("t4_err_sticky", start_err_o, 1'b1);

        // 5: asynchronous reset mid-fetch, stray beat in idle, then a clean fetch
        m_xt = 8'($urandom_range(255)); m_x = 8'($urandom_range(m_xt));
        m_y = 8'($urandom); m_yb = $urandom; m_cb = $urandom; m_cr = $urandom;
        lat = 3; ack_pct = 100;
        req_idx = 0; rsp_idx = 0; wr_idx = 0; due_q.delete(); mem_on = 1;
        drive_cfg();
        start_pend = 1;
        for (int i = 0; i < 200 && req_idx < 10; i++) step();
        chk("t5_reached_req10", req_idx >= 10, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        mem_on = 0; due_q.delete(); exp_wr = 0; prev_req = 0;
        step();
        step();
        rst_n = 1'b1;
        force_valid = 1;
        step();
        step();
        chk("t5_idle_after_stray", busy_o, 1'b0);
        run_fetch(0, -1);

        // 6: largest picture and bases near the top of the address space
        m_x = 8'd255; m_y = 8'd255; m_xt = 8'd255;
        m_yb = 32'hFFFF_F000; m_cb = 32'hFFFF_FF00; m_cr = 32'hFFFF_FFF0;
        lat = 1 + int'($urandom_range(5)); ack_pct = 70;
        run_fetch(0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
